// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_pkg
//  Description : Shared CSR map, status bit positions and engine state type
//                for the RSA modular-exponentiation accelerator.
//  Revision    : 1.0
// ============================================================================
package rsa_pkg;

    localparam logic [7:0] C_CSR_COMMAND     = 8'h00;
    localparam logic [7:0] C_CSR_STATUS      = 8'h00;
    localparam logic [7:0] C_CSR_TXADDR      = 8'h04;
    localparam logic [7:0] C_CSR_MES_ADDR    = 8'h08;
    localparam logic [7:0] C_CSR_KEY_ADDR    = 8'h0C;
    localparam logic [7:0] C_CSR_MOD_ADDR    = 8'h10;
    localparam logic [7:0] C_CSR_RN_ADDR     = 8'h14;
    localparam logic [7:0] C_CSR_R2N_ADDR    = 8'h18;
    localparam logic [7:0] C_CSR_KEYLEN_ADDR = 8'h1C;

    // Word indices into the CSR file (byte offset / 4)
    localparam int C_IDX_COMMAND = int'(C_CSR_COMMAND) / 4;
    localparam int C_IDX_TX      = int'(C_CSR_TXADDR) / 4;
    localparam int C_IDX_MES     = int'(C_CSR_MES_ADDR) / 4;
    localparam int C_IDX_KEY     = int'(C_CSR_KEY_ADDR) / 4;
    localparam int C_IDX_MOD     = int'(C_CSR_MOD_ADDR) / 4;
    localparam int C_IDX_RN      = int'(C_CSR_RN_ADDR) / 4;
    localparam int C_IDX_R2N     = int'(C_CSR_R2N_ADDR) / 4;
    localparam int C_IDX_KEYLEN  = int'(C_CSR_KEYLEN_ADDR) / 4;

    localparam int C_STATUS_DONE = 0;
    localparam int C_STATUS_BUSY = 1;

    typedef enum logic [2:0] {
        ENG_IDLE     = 3'd0,
        ENG_FETCH    = 3'd1,
        ENG_TOMONT   = 3'd2,
        ENG_LOOP     = 3'd3,
        ENG_FROMMONT = 3'd4,
        ENG_WRITE    = 3'd5
    } eng_state_e;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsa_accel_mont_mul.sv
`default_nettype none
// ============================================================================
//  Module      : mont_mul
//  Description : Bit-serial Montgomery multiplier, result = a*b*2^-WIDTH mod n.
//  Revision    : 1.0
// ============================================================================
module mont_mul
    import rsa_pkg::*;
#(
    parameter int WIDTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH+1:0] r_s;
    logic [CW-1:0]    r_cnt;
    logic             r_run;
    logic             r_fin;

    logic [WIDTH+1:0] w_add_b;
    logic [WIDTH+1:0] w_add_n;
    logic [WIDTH+1:0] w_red;
    logic             w_unused;

    // S stays below 2n between iterations, so WIDTH+2 bits never overflow
    always_comb begin
        w_add_b = r_s + (r_a[0] ? {2'b00, r_b} : '0);
        w_add_n = w_add_b + (w_add_b[0] ? {2'b00, r_n} : '0);
        w_red   = r_s - {2'b00, r_n};
    end

    assign w_unused = ^w_red[WIDTH+1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_n    <= '0;
            r_s    <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_fin  <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_n   <= n;
            r_s   <= '0;
            r_cnt <= '0;
            r_run <= 1'b1;
            r_fin <= 1'b0;
            done  <= 1'b0;
        end else if (r_run) begin
            r_s   <= w_add_n >> 1;
            r_a   <= r_a >> 1;
            r_cnt <= r_cnt + CW'(1);
            done  <= 1'b0;
            if (r_cnt == CW'(WIDTH - 1)) begin
                r_run <= 1'b0;
                r_fin <= 1'b1;
            end
        end else if (r_fin) begin
            result <= (r_s >= {2'b00, r_n}) ? w_red[WIDTH-1:0] : r_s[WIDTH-1:0];
            done   <= 1'b1;
            r_fin  <= 1'b0;
        end else begin
            done <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rsa_accel_top.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_accel_top
//  Description : RSA M^E mod N accelerator: AXI-Lite CSRs, operand memory and
//                Montgomery square-and-multiply engine.
//  Revision    : 1.0
// ============================================================================
module rsa_accel_top
    import rsa_pkg::*;
#(
    parameter int WIDTH     = 1024,
    parameter int MEM_WORDS = 8,
    parameter int MEM_AW    = 17,
    parameter int CSR_AW    = 12
) (
    input  logic                 clk,
    input  logic                 resetn,
    output logic                 leds,
    input  logic [CSR_AW-1:0]    s_axi_csrs_awaddr,
    input  logic                 s_axi_csrs_awvalid,
    output logic                 s_axi_csrs_awready,
    input  logic [31:0]          s_axi_csrs_wdata,
    input  logic [3:0]           s_axi_csrs_wstrb,
    input  logic                 s_axi_csrs_wvalid,
    output logic                 s_axi_csrs_wready,
    output logic [1:0]           s_axi_csrs_bresp,
    output logic                 s_axi_csrs_bvalid,
    input  logic                 s_axi_csrs_bready,
    input  logic [CSR_AW-1:0]    s_axi_csrs_araddr,
    input  logic                 s_axi_csrs_arvalid,
    output logic                 s_axi_csrs_arready,
    output logic [31:0]          s_axi_csrs_rdata,
    output logic [1:0]           s_axi_csrs_rresp,
    output logic                 s_axi_csrs_rvalid,
    input  logic                 s_axi_csrs_rready,
    input  logic [MEM_AW-1:0]    mem_addr,
    input  logic [WIDTH-1:0]     mem_din,
    output logic [WIDTH-1:0]     mem_dout,
    input  logic                 mem_en,
    input  logic [WIDTH/8-1:0]   mem_we
);

    localparam int MW = $clog2(MEM_WORDS);
    localparam int KW = $clog2(WIDTH + 1);
    localparam int BW = $clog2(WIDTH);

    // CSR / AXI state
    logic [31:0]       r_csr [8];
    logic              r_wr_ack;
    logic              r_arready;
    logic              r_rvalid;
    logic [31:0]       r_rdata;
    logic [CSR_AW-1:0] r_araddr;
    logic              r_busy;
    logic              r_done;

    // Engine state
    eng_state_e        r_state;
    eng_state_e        w_next;
    logic [2:0]        r_fidx;
    logic              r_mm_pend;
    logic              r_phase;
    logic [BW-1:0]     r_bit;
    logic [KW-1:0]     r_k;
    logic [WIDTH-1:0]  r_m, r_e, r_n, r_rn, r_r2n, r_x, r_acc;

    logic [WIDTH-1:0]  mem [MEM_WORDS];
    logic [WIDTH-1:0]  r_eng_rdata;

    logic              w_aw_accept, w_aw_mapped, w_ar_mapped, w_start;
    logic [2:0]        w_aw_idx, w_ar_idx;
    logic [31:0]       w_status, w_rd_val;
    logic [MW-1:0]     w_host_idx, w_eng_raddr, w_eng_waddr;
    logic              w_eng_we, w_mm_start, w_mm_done;
    logic [WIDTH-1:0]  w_mm_a, w_mm_b, w_mm_res;
    logic [15:0]       w_keylen, w_kclamp;
    logic [KW-1:0]     w_k_m1;
    logic              w_unused;

    assign w_aw_accept = !r_wr_ack && s_axi_csrs_awvalid && s_axi_csrs_wvalid;
    assign w_aw_idx    = s_axi_csrs_awaddr[4:2];
    assign w_aw_mapped = (s_axi_csrs_awaddr[CSR_AW-1:5] == '0) && (s_axi_csrs_awaddr[1:0] == 2'b00);
    assign w_ar_idx    = r_araddr[4:2];
    assign w_ar_mapped = (r_araddr[CSR_AW-1:5] == '0) && (r_araddr[1:0] == 2'b00);
    assign w_start     = w_aw_accept && w_aw_mapped && (w_aw_idx == 3'(C_IDX_COMMAND))
                         && s_axi_csrs_wstrb[0] && s_axi_csrs_wdata[0] && !r_busy && !r_done;

    always_comb begin
        w_status                = '0;
        w_status[C_STATUS_DONE] = r_done;
        w_status[C_STATUS_BUSY] = r_busy;
        w_rd_val                = '0;
        if (w_ar_mapped) begin
            w_rd_val = (w_ar_idx == 3'(C_IDX_COMMAND)) ? w_status : r_csr[w_ar_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            for (int i = 0; i < 8; i++) r_csr[i] <= '0;
            r_wr_ack  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_araddr  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (r_wr_ack) begin
                if (s_axi_csrs_bready) r_wr_ack <= 1'b0;
            end else if (w_aw_accept) begin
                r_wr_ack <= 1'b1;
                if (w_aw_mapped) begin
                    if (w_aw_idx == 3'(C_IDX_COMMAND)) begin
                        if (s_axi_csrs_wstrb[0] && !s_axi_csrs_wdata[0]) r_done <= 1'b0;
                    end else begin
                        r_csr[w_aw_idx] <= apply_wstrb(r_csr[w_aw_idx], s_axi_csrs_wdata,
                                                       s_axi_csrs_wstrb);
                    end
                end
            end
            if (w_start) r_busy <= 1'b1;
            if (r_state == ENG_WRITE) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end

            if (r_rvalid) begin
                if (s_axi_csrs_rready) begin
                    r_rvalid  <= 1'b0;
                    r_arready <= 1'b0;
                end
            end else if (r_arready) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_val;
            end else if (s_axi_csrs_arvalid) begin
                r_arready <= 1'b1;
                r_araddr  <= s_axi_csrs_araddr;
            end
        end
    end

    assign s_axi_csrs_awready = r_wr_ack;
    assign s_axi_csrs_wready  = r_wr_ack;
    assign s_axi_csrs_bvalid  = r_wr_ack;
    assign s_axi_csrs_bresp   = 2'b00;
    assign s_axi_csrs_arready = r_arready;
    assign s_axi_csrs_rvalid  = r_rvalid;
    assign s_axi_csrs_rdata   = r_rdata;
    assign s_axi_csrs_rresp   = 2'b00;
    assign leds               = r_done;

    // Operand memory; engine write is placed last so it wins a same-word collision
    assign w_host_idx  = mem_addr[7 +: MW];
    assign w_eng_waddr = r_csr[C_IDX_TX][7 +: MW];

    always_ff @(posedge clk) begin
        if (mem_en) begin
            for (int i = 0; i < WIDTH / 8; i++) begin
                if (mem_we[i]) mem[w_host_idx][8*i +: 8] <= mem_din[8*i +: 8];
            end
        end
        if (w_eng_we) mem[w_eng_waddr] <= r_acc;
        r_eng_rdata <= mem[w_eng_raddr];
    end

    always_ff @(posedge clk) begin
        if (resetn) mem_dout <= '0;
        else if (mem_en) mem_dout <= mem[w_host_idx];
    end

    always_comb begin
        case (r_fidx)
            3'd0:    w_eng_raddr = r_csr[C_IDX_MES][7 +: MW];
            3'd1:    w_eng_raddr = r_csr[C_IDX_KEY][7 +: MW];
            3'd2:    w_eng_raddr = r_csr[C_IDX_MOD][7 +: MW];
            3'd3:    w_eng_raddr = r_csr[C_IDX_RN][7 +: MW];
            3'd4:    w_eng_raddr = r_csr[C_IDX_R2N][7 +: MW];
            default: w_eng_raddr = r_csr[C_IDX_KEYLEN][7 +: MW];
        endcase
    end

    generate
        if (WIDTH >= 16) begin : g_keylen_wide
            assign w_keylen = r_eng_rdata[15:0];
        end else begin : g_keylen_narrow
            assign w_keylen = {{(16 - WIDTH){1'b0}}, r_eng_rdata};
        end
    endgenerate

    assign w_kclamp = (w_keylen > 16'(WIDTH)) ? 16'(WIDTH) : w_keylen;
    assign w_k_m1   = r_k - KW'(1);
    assign w_unused = ^{mem_addr[6:0], mem_addr[MEM_AW-1:7+MW], w_kclamp[15:KW], w_k_m1[KW-1:BW]};

    always_ff @(posedge clk) begin
        if (resetn) r_state <= ENG_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_mm_start = 1'b0;
        w_eng_we   = 1'b0;
        w_mm_a     = r_acc;
        w_mm_b     = r_acc;
        case (r_state)
            ENG_IDLE: begin
                if (w_start) w_next = ENG_FETCH;
            end
            ENG_FETCH: begin
                if (r_fidx == 3'd6) w_next = ENG_TOMONT;
            end
            ENG_TOMONT: begin
                w_mm_a     = r_m;
                w_mm_b     = r_r2n;
                w_mm_start = !r_mm_pend;
                if (w_mm_done && r_mm_pend) w_next = (r_k == '0) ? ENG_FROMMONT : ENG_LOOP;
            end
            ENG_LOOP: begin
                if (r_phase) w_mm_b = r_x;
                w_mm_start = !r_mm_pend;
                if (w_mm_done && r_mm_pend && (r_phase || !r_e[r_bit]) && (r_bit == '0))
                    w_next = ENG_FROMMONT;
            end
            ENG_FROMMONT: begin
                w_mm_b     = WIDTH'(1);
                w_mm_start = !r_mm_pend;
                if (w_mm_done && r_mm_pend) w_next = ENG_WRITE;
            end
            ENG_WRITE: begin
                w_eng_we = 1'b1;
                w_next   = ENG_IDLE;
            end
            default: w_next = ENG_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_fidx    <= '0;
            r_mm_pend <= 1'b0;
            r_phase   <= 1'b0;
            r_bit     <= '0;
            r_k       <= '0;
            r_m       <= '0;
            r_e       <= '0;
            r_n       <= '0;
            r_rn      <= '0;
            r_r2n     <= '0;
            r_x       <= '0;
            r_acc     <= '0;
        end else begin
            if (w_mm_start)     r_mm_pend <= 1'b1;
            else if (w_mm_done) r_mm_pend <= 1'b0;
            case (r_state)
                ENG_IDLE: r_fidx <= '0;
                ENG_FETCH: begin
                    // Read data lags the issued address by one cycle
                    if (r_fidx != 3'd6) r_fidx <= r_fidx + 3'd1;
                    case (r_fidx)
                        3'd1:    r_m   <= r_eng_rdata;
                        3'd2:    r_e   <= r_eng_rdata;
                        3'd3:    r_n   <= r_eng_rdata;
                        3'd4:    r_rn  <= r_eng_rdata;
                        3'd5:    r_r2n <= r_eng_rdata;
                        3'd6:    r_k   <= w_kclamp[KW-1:0];
                        default: ;
                    endcase
                end
                ENG_TOMONT: begin
                    if (w_mm_done && r_mm_pend) begin
                        r_x     <= w_mm_res;
                        r_acc   <= r_rn;
                        r_bit   <= w_k_m1[BW-1:0];
                        r_phase <= 1'b0;
                    end
                end
                ENG_LOOP: begin
                    if (w_mm_done && r_mm_pend) begin
                        r_acc <= w_mm_res;
                        if (!r_phase && r_e[r_bit]) begin
                            r_phase <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            if (r_bit != '0) r_bit <= r_bit - BW'(1);
                        end
                    end
                end
                ENG_FROMMONT: begin
                    if (w_mm_done && r_mm_pend) r_acc <= w_mm_res;
                end
                default: ;
            endcase
        end
    end

    mont_mul #(
        .WIDTH (WIDTH)
    ) u_mont_mul (
        .clk    (clk),
        .rst    (resetn),
        .start  (w_mm_start),
        .a      (w_mm_a),
        .b      (w_mm_b),
        .n      (r_n),
        .done   (w_mm_done),
        .result (w_mm_res)
    );

endmodule
`default_nettype wire

// File: tb/tb_rsa_accel_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rsa_accel_top
//  Description : Self-checking bench for rsa_accel_top at WIDTH=8.
//  Revision    : 1.0
// ============================================================================
module tb_rsa_accel_top;

    localparam int TW    = 8;
    localparam int TWORDS = 8;
    localparam int TMAW  = 17;
    localparam int TCAW  = 12;

    logic            clk = 1'b0;
    logic            resetn;
    logic            leds;
    logic [TCAW-1:0] awaddr, araddr;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0]     wdata, rdata;
    logic [3:0]      wstrb;
    logic [1:0]      bresp, rresp;
    logic            arvalid, arready, rvalid, rready;
    logic [TMAW-1:0] mem_addr;
    logic [TW-1:0]   mem_din, mem_dout;
    logic            mem_en;
    logic [TW/8-1:0] mem_we;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } csr_vec_t;

    csr_vec_t    vecs [7];
    logic [31:0] st;
    logic [TW-1:0] rd;

    always #5 clk = ~clk;

    rsa_accel_top #(
        .WIDTH (TW), .MEM_WORDS (TWORDS), .MEM_AW (TMAW), .CSR_AW (TCAW)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .leds               (leds),
        .s_axi_csrs_awaddr  (awaddr),
        .s_axi_csrs_awvalid (awvalid),
        .s_axi_csrs_awready (awready),
        .s_axi_csrs_wdata   (wdata),
        .s_axi_csrs_wstrb   (wstrb),
        .s_axi_csrs_wvalid  (wvalid),
        .s_axi_csrs_wready  (wready),
        .s_axi_csrs_bresp   (bresp),
        .s_axi_csrs_bvalid  (bvalid),
        .s_axi_csrs_bready  (bready),
        .s_axi_csrs_araddr  (araddr),
        .s_axi_csrs_arvalid (arvalid),
        .s_axi_csrs_arready (arready),
        .s_axi_csrs_rdata   (rdata),
        .s_axi_csrs_rresp   (rresp),
        .s_axi_csrs_rvalid  (rvalid),
        .s_axi_csrs_rready  (rready),
        .mem_addr           (mem_addr),
        .mem_din            (mem_din),
        .mem_dout           (mem_dout),
        .mem_en             (mem_en),
        .mem_we             (mem_we)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Reference: plain left-to-right square-and-multiply over the low k bits of E
    function automatic int unsigned ref_modexp(input int unsigned m, input int unsigned e,
                                               input int unsigned n, input int unsigned k);
        int unsigned r  = 1 % n;
        int          kk = (k > TW) ? TW : int'(k);
        for (int i = kk - 1; i >= 0; i--) begin
            r = (r * r) % n;
            if (e[i]) r = (r * m) % n;
        end
        return r;
    endfunction

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        do begin
            @(posedge clk); #1; n++;
        end while (!bvalid && n < 20);
        if (!bvalid) check("axi_bvalid_timeout", {31'b0, bvalid}, 32'h1);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        do begin
            @(posedge clk); #1; n++;
        end while (!rvalid && n < 20);
        if (!rvalid) check("axi_rvalid_timeout", {31'b0, rvalid}, 32'h1);
        d = rdata;
        arvalid = 1'b0; rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic mem_write(input int idx, input logic [TW-1:0] d);
        mem_addr = TMAW'(idx) << 7; mem_din = d; mem_en = 1'b1; mem_we = '1;
        @(posedge clk); #1;
        mem_en = 1'b0; mem_we = '0;
    endtask

    task automatic mem_read(input int idx, output logic [TW-1:0] d);
        mem_addr = TMAW'(idx) << 7; mem_en = 1'b1; mem_we = '0;
        @(posedge clk); #1;
        d = mem_dout;
        mem_en = 1'b0;
    endtask

    task automatic set_ptrs(input logic [31:0] tx);
        axi_write(12'h04, tx, 4'hF);
        axi_write(12'h08, 32'h080, 4'hF);
        axi_write(12'h0C, 32'h100, 4'hF);
        axi_write(12'h10, 32'h180, 4'hF);
        axi_write(12'h14, 32'h200, 4'hF);
        axi_write(12'h18, 32'h280, 4'hF);
        axi_write(12'h1C, 32'h300, 4'hF);
    endtask

    task automatic load_ops(input int unsigned m, input int unsigned e,
                            input int unsigned n, input int unsigned k);
        mem_write(1, TW'(m));
        mem_write(2, TW'(e));
        mem_write(3, TW'(n));
        mem_write(4, TW'(256 % n));
        mem_write(5, TW'(65536 % n));
        mem_write(6, TW'(k));
    endtask

    task automatic wait_done();
        logic [31:0] s = '0;
        int          n = 0;
        do begin
            axi_read(12'h00, s); n++;
        end while (!s[0] && n < 400);
        check("status_done", s, 32'h1);
    endtask

    task automatic run_case(input string name, input int unsigned m, input int unsigned e,
                            input int unsigned n, input int unsigned k);
        logic [31:0] s;
        logic [TW-1:0] r;
        load_ops(m, e, n, k);
        axi_write(12'h00, 32'h1, 4'hF);
        axi_read(12'h00, s);
        check({name, "_busy"}, s, 32'h2);
        wait_done();
        mem_read(0, r);
        check(name, {24'b0, r}, ref_modexp(m, e, n, k));
        check({name, "_leds"}, {31'b0, leds}, 32'h1);
        axi_write(12'h00, 32'h0, 4'hF);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{12'h04, 32'h0000_1234, 4'hF, 32'h0000_1234};
        vecs[1] = '{12'h08, 32'hAABB_CCDD, 4'hF, 32'hAABB_CCDD};
        vecs[2] = '{12'h08, 32'h1122_3344, 4'h2, 32'hAABB_33DD};
        vecs[3] = '{12'h0C, 32'hFFFF_FFFF, 4'h9, 32'hFF00_00FF};
        vecs[4] = '{12'h20, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000};
        vecs[5] = '{12'h1C, 32'h0000_0380, 4'hF, 32'h0000_0380};
        vecs[6] = '{12'h00, 32'h0000_0000, 4'hF, 32'h0000_0000};

        resetn = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        mem_addr = '0; mem_din = '0; mem_en = 0; mem_we = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;

        check("reset_outputs", {24'b0, leds, awready, wready, bvalid, arready, rvalid, bresp == 2'b00, rresp == 2'b00},
              32'h3);
        check("reset_mem_dout", {24'b0, mem_dout}, 32'h0);
        axi_read(12'h00, st);
        check("reset_status", st, 32'h0);

        for (int i = 0; i < 7; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            axi_read(vecs[i].addr, st);
            check($sformatf("csr_vec%0d", i), st, vecs[i].exp);
        end

        mem_write(1, 8'h5A);
        mem_read(1, rd);
        check("mem_rw", {24'b0, rd}, 32'h5A);
        mem_addr = TMAW'(1) << 7; mem_din = 8'hFF; mem_en = 1'b1; mem_we = '0;
        @(posedge clk); #1;
        mem_en = 1'b0;
        mem_read(1, rd);
        check("mem_no_we", {24'b0, rd}, 32'h5A);

        set_ptrs(32'h0);
        load_ops(5, 3, 13, 2);
        axi_write(12'h00, 32'h1, 4'hF);
        wait_done();
        mem_read(0, rd);
        check("dir_5_3_13", {24'b0, rd}, 32'h8);
        check("dir_leds", {31'b0, leds}, 32'h1);
        axi_write(12'h00, 32'h1, 4'hF);
        axi_read(12'h00, st);
        check("start_while_done", st, 32'h1);
        axi_write(12'h00, 32'h0, 4'hF);
        axi_read(12'h00, st);
        check("clear_done", st, 32'h0);
        check("clear_leds", {31'b0, leds}, 32'h0);

        run_case("keylen0", 5, 3, 13, 0);
        run_case("keylen_clamp", 7, 8'hB5, 251, 12);

        for (int t = 0; t < 10; t++) begin
            int unsigned n, m, e, k;
            n = 2 * $urandom_range(1, 127) + 1;
            m = $urandom_range(0, n - 1);
            e = $urandom_range(0, 255);
            k = $urandom_range(0, 11);
            run_case($sformatf("rand%0d", t), m, e, n, k);
        end

        // Reset in the middle of the exponent loop
        mem_write(7, 8'hA5);
        axi_write(12'h04, 32'h380, 4'hF);
        load_ops(5, 8'hFF, 13, 8);
        axi_write(12'h00, 32'h1, 4'hF);
        repeat (40) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b0;
        axi_read(12'h00, st);
        check("midreset_status", st, 32'h0);
        check("midreset_leds", {31'b0, leds}, 32'h0);
        repeat (400) @(posedge clk);
        #1;
        mem_read(7, rd);
        check("midreset_mem", {24'b0, rd}, 32'hA5);
        set_ptrs(32'h380);
        axi_write(12'h00, 32'h1, 4'hF);
        wait_done();
        mem_read(7, rd);
        check("after_reset_run", {24'b0, rd}, ref_modexp(5, 8'hFF, 13, 8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
